// File: rtl/rc_pkg.sv
// rc_pkg: shared types and helpers for the RC charge sequencer.
// Optional feature macro used by the sequencer: RC_SEQ_TIMEOUT_EN.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
    HOLD,
    DISCHARGE,
    DONE,
    ABORT
  } rc_seq_state_e;

  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_CHARGE = 2'b01;
  localparam logic [1:0] PH_DISCH  = 2'b10;
  localparam logic [1:0] PH_ABORT  = 2'b11;

  function automatic real rc_abs(input real d);
    return (d < 0.0) ? -d : d;
  endfunction

endpackage

// File: rtl/rc_settle_detect.sv
// rc_settle_detect: counts consecutive in-tolerance samples of v_meas
// against target. settled is asserted combinationally on the cycle whose
// sample completes the SETTLE_CNT-long run, so the FSM moves on that edge.
module rc_settle_detect #(
  parameter real TOL        = 1e-3,
  parameter int  SETTLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  real  target,
  input  real  v_meas,
  output logic settled
);
  import rc_pkg::*;

  localparam int            CW   = $clog2(SETTLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CNT - 1);
  localparam logic [CW-1:0] MAX  = CW'(SETTLE_CNT);

  logic [CW-1:0] r_stable_cnt;
  logic          w_in_tol;

  // Exactly TOL away from target still counts as settled.
  assign w_in_tol = (rc_abs(target - v_meas) <= TOL);
  assign settled  = w_in_tol && (r_stable_cnt >= LAST);

  // Run-length of in-tolerance samples; restarts on phase change, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_cnt <= '0;
    end else if (clr || !w_in_tol) begin
      r_stable_cnt <= '0;
    end else if (r_stable_cnt != MAX) begin
      r_stable_cnt <= r_stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rc_charge_sequencer.sv
// rc_charge_sequencer: drives the RC source voltage through charge, hold and
// discharge, advancing only once v_meas has settled on each target.
// Optional macro RC_SEQ_TIMEOUT_EN adds a per-phase timeout that aborts the
// sequence (vi back to V_LOW, sticky err) instead of waiting forever.
//
// state     | meaning
// IDLE      | vi = V_LOW, waiting for start
// CHARGE    | vi = V_HIGH, waiting for v_meas to settle on V_HIGH
// HOLD      | vi = V_HIGH for HOLD_CYCLES cycles
// DISCHARGE | vi = V_LOW, waiting for v_meas to settle on V_LOW
// DONE      | one-cycle done pulse, then IDLE
// ABORT     | timeout seen (macro only), vi = V_LOW, then DONE
module rc_charge_sequencer #(
  parameter real V_HIGH         = 1.0,
  parameter real V_LOW          = 0.0,
  parameter real TOL            = 1e-3,
  parameter int  SETTLE_CNT     = 4,
  parameter int  HOLD_CYCLES    = 8,
  parameter int  TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  real        v_meas,
  output real        vi,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase,
  output logic       err
);
  import rc_pkg::*;

  localparam int            HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  rc_seq_state_e r_state;
  rc_seq_state_e w_next;
  logic [HW-1:0] r_hold_cnt;
  logic          w_settled;
  logic          w_clr;
  logic          w_settling;
  logic          w_timeout;
  real           w_target;
  real           r_vi;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_phase;

  assign w_settling = (r_state == CHARGE) || (r_state == DISCHARGE);
  assign w_target   = (r_state == DISCHARGE) ? V_LOW : V_HIGH;
  // Clearing on the entry edge means the first counted sample is the one
  // taken after vi has already moved to the new target.
  assign w_clr      = !w_settling || (w_next != r_state);

  rc_settle_detect #(
    .TOL        (TOL),
    .SETTLE_CNT (SETTLE_CNT)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .target  (w_target),
    .v_meas  (v_meas),
    .settled (w_settled)
  );

`ifdef RC_SEQ_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_phase_cnt;
  logic          r_err;

  assign w_timeout = w_settling && (r_phase_cnt == TO_LAST);
  assign err       = r_err;

  // Cycles spent in the current CHARGE/DISCHARGE phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_cnt <= '0;
    end else if (w_clr) begin
      r_phase_cnt <= '0;
    end else if (r_phase_cnt != TO_MAX) begin
      r_phase_cnt <= r_phase_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_err <= 1'b0;
    end else if (w_next == ABORT) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; settle wins over a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = CHARGE;
      CHARGE:    if (w_settled) w_next = HOLD;
                 else if (w_timeout) w_next = ABORT;
      HOLD:      if (r_hold_cnt == HOLD_LAST) w_next = DISCHARGE;
      DISCHARGE: if (w_settled) w_next = DONE;
                 else if (w_timeout) w_next = ABORT;
      DONE:      w_next = IDLE;
`ifdef RC_SEQ_TIMEOUT_EN
      ABORT:     w_next = DONE;
`endif
      default:   w_next = IDLE;
    endcase
  end

  // Cycles spent in HOLD; zero whenever not holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (r_state != HOLD) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HOLD_MAX) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Outputs registered from the next state so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vi    <= V_LOW;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= PH_IDLE;
    end else begin
      r_vi   <= ((w_next == CHARGE) || (w_next == HOLD)) ? V_HIGH : V_LOW;
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      case (w_next)
        IDLE:         r_phase <= PH_IDLE;
        CHARGE, HOLD: r_phase <= PH_CHARGE;
        DISCHARGE:    r_phase <= PH_DISCH;
        ABORT:        r_phase <= PH_ABORT;
        default:      r_phase <= r_phase;
      endcase
    end
  end

  assign vi    = r_vi;
  assign busy  = r_busy;
  assign done  = r_done;
  assign phase = r_phase;

endmodule

// File: tb/tb_rc_charge_sequencer.sv
// Bench for rc_charge_sequencer with a discretized RC plant
// v' = v + 0.5*(vi - v); v_meas can be overridden for boundary cases.
// Timeout scenario is built only when RC_SEQ_TIMEOUT_EN is defined.
module tb_rc_charge_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  real        v_meas;
  real        vi;
  logic       busy;
  logic       done;
  logic [1:0] phase;
  logic       err;

  real  v_rc;
  logic force_en;
  real  force_val;

  int checks;
  int errors;

  rc_charge_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .v_meas (v_meas),
    .vi     (vi),
    .busy   (busy),
    .done   (done),
    .phase  (phase),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RC plant
  always @(posedge clk or posedge rst) begin
    if (rst) v_rc <= 0.0;
    else     v_rc <= v_rc + 0.5 * (vi - v_rc);
  end

  assign v_meas = force_en ? force_val : v_rc;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    force_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents start for edge E0 and returns at the negedge after it (k = 0).
  task automatic launch(input bit keep);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    force_en = 1'b0;
    force_val = 0.0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (vi != 0.0)   begin errors++; $display("FAIL rst_vi got %f want 0.0", vi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL rst_phase got %b want 00", phase); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    rst = 1'b0;
    // Mid-CHARGE async reset
    launch(1'b0);
    step();
    step();
    checks++; if (vi != 1.0) begin errors++; $display("FAIL midrst_pre_vi got %f want 1.0", vi); end
    #1 rst = 1'b1;
    #1;
    checks++; if (vi != 0.0)   begin errors++; $display("FAIL midrst_vi got %f want 0.0", vi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL midrst_phase got %b want 00", phase); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done cyc=%0d got %b want 0", i, done); end
    end
    rst = 1'b0;
  endtask

  // Natural RC: charge settles at E14, HOLD to E22, discharge settles at E36.
  task automatic test_sequence();
    real        e_vi;
    logic [1:0] e_ph;
    do_reset();
    launch(1'b0);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      e_vi = (k <= 21) ? 1.0 : 0.0;
      e_ph = (k <= 21) ? 2'b01 : ((k <= 36) ? 2'b10 : 2'b00);
      checks++; if (vi != e_vi) begin errors++; $display("FAIL seq_vi k=%0d got %f want %f", k, vi, e_vi); end
      checks++; if (phase !== e_ph) begin errors++; $display("FAIL seq_phase k=%0d got %b want %b", k, phase, e_ph); end
      checks++; if (done !== (k == 36)) begin errors++; $display("FAIL seq_done k=%0d got %b want %b", k, done, (k == 36)); end
      checks++; if (busy !== (k <= 36)) begin errors++; $display("FAIL seq_busy k=%0d got %b want %b", k, busy, (k <= 36)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL seq_err k=%0d got %b want 0", k, err); end
    end
  endtask

  // Forced v_meas: out-of-tol glitch at E4 restarts the run (settle at E8,
  // vi drops at E16); discharge at exactly TOL counts, glitch at E20 delays
  // settle to E24.
  task automatic test_settle_boundary();
    real        e_vi;
    logic [1:0] e_ph;
    int         e;
    do_reset();
    force_en = 1'b1;
    force_val = 0.9995;
    launch(1'b0);
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) step();
      e_vi = (k <= 15) ? 1.0 : 0.0;
      e_ph = (k <= 15) ? 2'b01 : ((k <= 24) ? 2'b10 : 2'b00);
      checks++; if (vi != e_vi) begin errors++; $display("FAIL bnd_vi k=%0d got %f want %f", k, vi, e_vi); end
      checks++; if (phase !== e_ph) begin errors++; $display("FAIL bnd_phase k=%0d got %b want %b", k, phase, e_ph); end
      checks++; if (done !== (k == 24)) begin errors++; $display("FAIL bnd_done k=%0d got %b want %b", k, done, (k == 24)); end
      e = k + 1;
      if (e == 4)       force_val = 1.0 - 1.001e-3;
      else if (e <= 16) force_val = 0.9995;
      else if (e == 20) force_val = 1.001e-3;
      else              force_val = 1e-3;
    end
    force_en = 1'b0;
  endtask

  // start held high: DONE ignores it, next sequence begins from IDLE at E38.
  task automatic test_back_to_back();
    real e_vi;
    do_reset();
    launch(1'b1);
    for (int k = 0; k <= 38; k++) begin
      if (k > 0) step();
      e_vi = ((k <= 21) || (k == 38)) ? 1.0 : 0.0;
      checks++; if (vi != e_vi) begin errors++; $display("FAIL b2b_vi k=%0d got %f want %f", k, vi, e_vi); end
      checks++; if (done !== (k == 36)) begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, (k == 36)); end
      checks++; if (busy !== (k != 37)) begin errors++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, (k != 37)); end
    end
    start = 1'b0;
  endtask

`ifdef RC_SEQ_TIMEOUT_EN
  // v_meas stuck at 0.5: abort after 64 CHARGE cycles (E64), DONE at E65.
  task automatic test_timeout();
    real        e_vi;
    logic [1:0] e_ph;
    do_reset();
    force_en = 1'b1;
    force_val = 0.5;
    launch(1'b0);
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) step();
      e_vi = (k <= 63) ? 1.0 : 0.0;
      e_ph = (k <= 63) ? 2'b01 : ((k <= 65) ? 2'b11 : 2'b00);
      checks++; if (vi != e_vi) begin errors++; $display("FAIL to_vi k=%0d got %f want %f", k, vi, e_vi); end
      checks++; if (phase !== e_ph) begin errors++; $display("FAIL to_phase k=%0d got %b want %b", k, phase, e_ph); end
      checks++; if (err !== (k >= 64)) begin errors++; $display("FAIL to_err k=%0d got %b want %b", k, err, (k >= 64)); end
      checks++; if (done !== (k == 65)) begin errors++; $display("FAIL to_done k=%0d got %b want %b", k, done, (k == 65)); end
      checks++; if (busy !== (k <= 65)) begin errors++; $display("FAIL to_busy k=%0d got %b want %b", k, busy, (k <= 65)); end
    end
    launch(1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b want 0", err); end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequence();
    test_settle_boundary();
    test_back_to_back();
`ifdef RC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
